// File: rtl/ram_responder.sv
// -----------------------------------------------------------------------------
// ram_responder
// -----------------------------------------------------------------------------
// Memory-side responder for the CPU's unified instruction/data RAM.
// It accepts single-beat read/write requests, holds each one for a programmable
// number of wait states, and then completes it with a one-cycle ready pulse.
// The fetch/decode/execute sequencer gets a memory that can stall it, instead of
// an ideal zero-latency array.
//
// Timing: a request sampled on edge E0 is performed on edge E0 + WAIT_STATES + 1.
// ready (and err, when it applies) is high for the one cycle after that edge.
// busy is high from the accept edge until the access edge.
//
// Parameters
//   ADDR_W       address width in bits
//   DATA_W       data word width in bits
//   DEPTH        number of implemented words (must be <= 2**ADDR_W)
//   WAIT_STATES  extra cycles inserted before each access completes (0..15)
//
// Ports
//   clk        in   system clock, rising edge active
//   rst        in   asynchronous, active-high reset
//   req        in   access request, sampled while idle or completing
//   readwrite  in   1 = write, 0 = read (sampled with req)
//   addr       in   word address (sampled with req)
//   wdata      in   write data (sampled with req)
//   rdata      out  read data, updated only when a read completes
//   ready      out  one-cycle completion pulse
//   err        out  one-cycle pulse with ready when addr >= DEPTH
//   busy       out  high while a request is latched and not yet completed
// -----------------------------------------------------------------------------
module ram_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              readwrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    // Width of the physical word index into the array.
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH can equal 2**ADDR_W, so the limit needs one extra bit.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Value loaded into the wait counter on every accept.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State and latched request
    // -------------------------------------------------------------------------
    state_t            r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            w_state_next;
    logic [3:0]        w_cnt_next;
    logic              w_accept;
    logic              w_access;
    logic              w_ready;
    logic              w_busy;
    logic              w_in_range;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_idx;

    // -------------------------------------------------------------------------
    // Address decode for the latched request
    // -------------------------------------------------------------------------
    assign w_in_range = ({1'b0, r_addr} < DEPTH_LIM);
    assign w_idx      = r_addr[IDX_W-1:0];

    // Out-of-range writes are dropped so they never alias onto a real word.
    assign w_mem_we   = w_access & r_we & w_in_range;

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case statement;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_access     = 1'b0;
        w_ready      = (r_state == S_DONE);
        w_busy       = (r_state == S_WAIT);

        case (r_state)
            // Completing a request also accepts the next one, so a held req
            // runs accesses back to back without passing through IDLE.
            S_IDLE, S_DONE: begin
                if (req) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                    w_cnt_next   = WAIT_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end

            // The counter runs down the programmed wait states. The edge after
            // it reaches zero performs the access, which gives the one cycle
            // of latency beyond WAIT_STATES. req is ignored here.
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_access     = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // Request latch, completion flags and read data register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            // Inputs are captured only on the accept edge, so activity on the
            // bus while busy cannot disturb the pending access.
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= readwrite;
            end

            // err is high only for the cycle after the access edge, matching ready.
            r_err <= w_access & ~w_in_range;

            // rdata changes only when a read completes; writes leave it alone.
            if (w_access && !r_we) begin
                r_rdata <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage array: synchronous write, read through the r_rdata register
    // -------------------------------------------------------------------------
    // NOTE: the array has no reset; its contents survive rst, and leaving the
    // reset off lets the array map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rdata = r_rdata;
    assign ready = w_ready;
    assign err   = r_err;
    assign busy  = w_busy;

endmodule

// File: tb/tb_ram_responder.sv
// -----------------------------------------------------------------------------
// tb_ram_responder
// -----------------------------------------------------------------------------
// Self-checking bench for ram_responder. Three instances share clk and rst:
//   k=0 : WAIT_STATES=1, DEPTH=128 (latency, out-of-range, reset mid-write)
//   k=1 : WAIT_STATES=0, DEPTH=256 (back-to-back with req held high)
//   k=2 : WAIT_STATES=3, DEPTH=256 (bus activity ignored while waiting)
// The reference model is a per-instance word array plus the last read value.
// Expected latency is WAIT_STATES + 1 edges after the accept edge.
// -----------------------------------------------------------------------------
module tb_ram_responder;

    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst;

    logic       req_s   [NI];
    logic       rw_s    [NI];
    logic [7:0] addr_s  [NI];
    logic [7:0] wdata_s [NI];
    logic [7:0] rdata_s [NI];
    logic       ready_s [NI];
    logic       err_s   [NI];
    logic       busy_s  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [7:0] mdl_mem   [NI][256];
    bit         mdl_known [NI][256];
    logic [7:0] mdl_rdata [NI];

    always #5 clk = ~clk;

    ram_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst(rst), .req(req_s[0]), .readwrite(rw_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ready(ready_s[0]), .err(err_s[0]),
        .busy(busy_s[0])
    );

    ram_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .readwrite(rw_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ready(ready_s[1]), .err(err_s[1]),
        .busy(busy_s[1])
    );

    ram_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u_dut2 (
        .clk(clk), .rst(rst), .req(req_s[2]), .readwrite(rw_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ready(ready_s[2]), .err(err_s[2]),
        .busy(busy_s[2])
    );

    function automatic int ws_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 128 : 256;
    endfunction

    // Model of one access: returns the expected err flag and the rdata value
    // expected at the ready pulse, and updates the model state.
    task automatic model_access(input int k, input bit we, input logic [7:0] a,
                                input logic [7:0] d, output logic exp_err,
                                output logic [7:0] exp_rd);
        exp_err = (int'(a) >= depth_of(k));
        if (we) begin
            if (!exp_err) begin
                mdl_mem[k][a]   = d;
                mdl_known[k][a] = 1'b1;
            end
        end else begin
            mdl_rdata[k] = exp_err ? 8'h00 : mdl_mem[k][a];
        end
        exp_rd = mdl_rdata[k];
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) mdl_rdata[k] = 8'h00;
    endtask

    // Drives one request on instance k starting at posedge+1 and observes it.
    // lat is the number of edges after the accept edge until ready (-1 on
    // timeout); shape_ok is cleared if busy/ready/err misbehave around it.
    task automatic access(input int k, input bit we, input logic [7:0] a,
                          input logic [7:0] d, output int lat, output logic err_o,
                          output logic [7:0] rd_o, output bit shape_ok);
        shape_ok = 1'b1;
        lat      = -1;
        err_o    = 1'bx;
        rd_o     = 8'hxx;
        req_s[k]   = 1'b1;
        rw_s[k]    = we;
        addr_s[k]  = a;
        wdata_s[k] = d;
        @(posedge clk); #1;
        req_s[k] = 1'b0;
        if (busy_s[k] !== 1'b1 || ready_s[k] !== 1'b0) shape_ok = 1'b0;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if (ready_s[k] === 1'b1) begin
                lat   = j;
                err_o = err_s[k];
                rd_o  = rdata_s[k];
                if (busy_s[k] !== 1'b0) shape_ok = 1'b0;
                break;
            end
            if (busy_s[k] !== 1'b1 || err_s[k] !== 1'b0) shape_ok = 1'b0;
        end
        if (lat > 0) begin
            @(posedge clk); #1;
            if (ready_s[k] !== 1'b0 || err_s[k] !== 1'b0 || busy_s[k] !== 1'b0)
                shape_ok = 1'b0;
        end
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            req_s[k] = 1'b0; rw_s[k] = 1'b0; addr_s[k] = 8'h00; wdata_s[k] = 8'h00;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({ready_s[k], err_s[k], busy_s[k]} !== 3'b000 || rdata_s[k] !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: ready/err/busy=%b%b%b rdata=%h, want 000 rdata=00",
                         k, ready_s[k], err_s[k], busy_s[k], rdata_s[k]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        model_access(0, 1'b1, 8'h10, 8'hA5, xe, xrd);
        access(0, 1'b1, 8'h10, 8'hA5, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== xe || rd !== xrd || !ok) begin
            n_fail++;
            $display("FAIL write_0x10: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=%b rdata=%h shape=1",
                     lat, e, rd, ok, xe, xrd);
        end
        model_access(0, 1'b0, 8'h10, 8'h00, xe, xrd);
        access(0, 1'b0, 8'h10, 8'h00, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== xe || rd !== 8'hA5 || !ok) begin
            n_fail++;
            $display("FAIL read_0x10: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=%b rdata=a5 shape=1",
                     lat, e, rd, ok, xe);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (rdata_s[0] !== 8'hA5 || ready_s[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL rdata_hold[%0d]: rdata=%h ready=%b, want a5 ready=0",
                         i, rdata_s[0], ready_s[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic xe; logic [7:0] xrd_w, xrd_r;
        model_access(1, 1'b1, 8'h20, 8'h3C, xe, xrd_w);
        model_access(1, 1'b0, 8'h20, 8'h00, xe, xrd_r);
        req_s[1] = 1'b1; rw_s[1] = 1'b1; addr_s[1] = 8'h20; wdata_s[1] = 8'h3C;
        @(posedge clk); #1;                       // write accepted
        rw_s[1] = 1'b0; wdata_s[1] = 8'h00;       // queue the read, req held
        n_checks++;
        if (busy_s[1] !== 1'b1 || ready_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b ready=%b, want busy=1 ready=0", busy_s[1], ready_s[1]);
        end
        @(posedge clk); #1;                       // write performed
        n_checks++;
        if (ready_s[1] !== 1'b1 || busy_s[1] !== 1'b0 || err_s[1] !== 1'b0 || rdata_s[1] !== xrd_w) begin
            n_fail++;
            $display("FAIL b2b_write_done: ready=%b busy=%b err=%b rdata=%h, want 1 0 0 rdata=%h",
                     ready_s[1], busy_s[1], err_s[1], rdata_s[1], xrd_w);
        end
        @(posedge clk); #1;                       // read accepted straight from DONE
        req_s[1] = 1'b0;
        n_checks++;
        if (ready_s[1] !== 1'b0 || busy_s[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_read_accept: ready=%b busy=%b, want ready=0 busy=1", ready_s[1], busy_s[1]);
        end
        @(posedge clk); #1;                       // read performed
        n_checks++;
        if (ready_s[1] !== 1'b1 || rdata_s[1] !== xrd_r || err_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_read_done: ready=%b rdata=%h err=%b, want ready=1 rdata=%h err=0",
                     ready_s[1], rdata_s[1], err_s[1], xrd_r);
        end
        @(posedge clk); #1;
        n_checks++;
        if (ready_s[1] !== 1'b0 || busy_s[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: ready=%b busy=%b, want 0 0", ready_s[1], busy_s[1]);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        model_access(0, 1'b1, 8'h90, 8'hFF, xe, xrd);
        access(0, 1'b1, 8'h90, 8'hFF, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== 1'b1 || rd !== xrd || !ok) begin
            n_fail++;
            $display("FAIL oor_write: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=1 rdata=%h shape=1",
                     lat, e, rd, ok, xrd);
        end
        model_access(0, 1'b0, 8'h10, 8'h00, xe, xrd);
        access(0, 1'b0, 8'h10, 8'h00, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== xrd || !ok) begin
            n_fail++;
            $display("FAIL oor_alias_0x10: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=0 rdata=%h shape=1",
                     lat, e, rd, ok, xrd);
        end
        model_access(0, 1'b0, 8'h90, 8'h00, xe, xrd);
        access(0, 1'b0, 8'h90, 8'h00, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== 1'b1 || rd !== 8'h00 || !ok) begin
            n_fail++;
            $display("FAIL oor_read: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=1 rdata=00 shape=1",
                     lat, e, rd, ok);
        end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        int pulses;
        model_access(0, 1'b1, 8'h05, 8'h11, xe, xrd);
        access(0, 1'b1, 8'h05, 8'h11, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || !ok) begin
            n_fail++;
            $display("FAIL midrst_setup: lat=%0d shape=%0d, want lat=2 shape=1", lat, ok);
        end
        req_s[0] = 1'b1; rw_s[0] = 1'b1; addr_s[0] = 8'h05; wdata_s[0] = 8'h77;
        @(posedge clk); #1;
        req_s[0] = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (busy_s[0] !== 1'b0 || ready_s[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_immediate: busy=%b ready=%b, want 0 0", busy_s[0], ready_s[0]);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready_s[0] !== 1'b0) pulses++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ready_s[0] !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_ready: ready seen %0d cycles, want 0", pulses);
        end
        model_access(0, 1'b0, 8'h05, 8'h00, xe, xrd);
        access(0, 1'b0, 8'h05, 8'h00, lat, e, rd, ok);
        n_checks++;
        if (lat !== 2 || e !== 1'b0 || rd !== 8'h11 || !ok) begin
            n_fail++;
            $display("FAIL midrst_readback: lat=%0d err=%b rdata=%h shape=%0d, want lat=2 err=0 rdata=11 shape=1",
                     lat, e, rd, ok);
        end
    endtask

    task automatic test_wait_ignore();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        int pulses, first;
        model_access(2, 1'b1, 8'h40, 8'h5A, xe, xrd);
        req_s[2] = 1'b1; rw_s[2] = 1'b1; addr_s[2] = 8'h40; wdata_s[2] = 8'h5A;
        @(posedge clk); #1;                       // accept edge
        pulses = 0; first = -1;
        for (int i = 1; i <= 4; i++) begin
            req_s[2]   = 1'($urandom_range(0, 1));
            rw_s[2]    = 1'($urandom_range(0, 1));
            addr_s[2]  = 8'(8'h41 + $urandom_range(0, 100));
            wdata_s[2] = 8'($urandom);
            if (wdata_s[2] == 8'h5A) wdata_s[2] = 8'hA5;
            @(posedge clk); #1;
            if (ready_s[2] === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        req_s[2] = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            @(posedge clk); #1;
            if (ready_s[2] === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        n_checks++;
        if (pulses !== 1 || first !== 4) begin
            n_fail++;
            $display("FAIL wait_ignore_ready: pulses=%0d first=%0d, want pulses=1 first=4", pulses, first);
        end
        model_access(2, 1'b0, 8'h40, 8'h00, xe, xrd);
        access(2, 1'b0, 8'h40, 8'h00, lat, e, rd, ok);
        n_checks++;
        if (lat !== 4 || e !== 1'b0 || rd !== 8'h5A || !ok) begin
            n_fail++;
            $display("FAIL wait_ignore_data: lat=%0d err=%b rdata=%h shape=%0d, want lat=4 err=0 rdata=5a shape=1",
                     lat, e, rd, ok);
        end
    endtask

    task automatic test_random();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        int k; bit we; logic [7:0] a, d;
        for (int n = 0; n < 60; n++) begin
            k  = $urandom_range(0, NI - 1);
            we = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00);
            d  = 8'($urandom);
            // Never read a word the model has not seen written.
            if (!we && int'(a) < depth_of(k) && !mdl_known[k][a]) we = 1'b1;
            model_access(k, we, a, d, xe, xrd);
            access(k, we, a, d, lat, e, rd, ok);
            n_checks++;
            if (lat !== ws_of(k) + 1 || e !== xe || rd !== xrd || !ok) begin
                n_fail++;
                $display("FAIL random[%0d] k=%0d we=%0d a=%h: lat=%0d err=%b rdata=%h shape=%0d, want lat=%0d err=%b rdata=%h shape=1",
                         n, k, we, a, lat, e, rd, ok, ws_of(k) + 1, xe, xrd);
            end
        end
    endtask

    task automatic test_async_reset_values();
        int lat; logic e; logic [7:0] rd; bit ok; logic xe; logic [7:0] xrd;
        for (int k = 0; k < NI; k++) begin
            model_access(k, 1'b1, 8'h33, 8'(8'hC3 + k), xe, xrd);
            access(k, 1'b1, 8'h33, 8'(8'hC3 + k), lat, e, rd, ok);
            model_access(k, 1'b0, 8'h33, 8'h00, xe, xrd);
            access(k, 1'b0, 8'h33, 8'h00, lat, e, rd, ok);
            n_checks++;
            if (rd !== xrd || lat !== ws_of(k) + 1 || !ok) begin
                n_fail++;
                $display("FAIL prereset_read[%0d]: rdata=%h lat=%0d shape=%0d, want rdata=%h lat=%0d shape=1",
                         k, rd, lat, ok, xrd, ws_of(k) + 1);
            end
        end
        // Leave instance 2 busy so the reset has state to clear.
        req_s[2] = 1'b1; rw_s[2] = 1'b1; addr_s[2] = 8'h34; wdata_s[2] = 8'h99;
        @(posedge clk); #1;
        req_s[2] = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if ({ready_s[k], err_s[k], busy_s[k]} !== 3'b000 || rdata_s[k] !== mdl_rdata[k]) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: ready/err/busy=%b%b%b rdata=%h, want 000 rdata=%h",
                         k, ready_s[k], err_s[k], busy_s[k], rdata_s[k], mdl_rdata[k]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    initial begin
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 256; a++) begin
                mdl_mem[k][a]   = 8'h00;
                mdl_known[k][a] = 1'b0;
            end
        test_reset();
        test_write_read();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_write();
        test_wait_ignore();
        test_random();
        test_async_reset_values();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
